// File: rtl/nios_system_create_block_sched_pkg.sv
// Shared constants for the block-creation scheduler: register map, CTRL/STATUS bit positions, FSM states.
package nios_system_create_block_sched_pkg;

  localparam int ID_W  = 3;
  localparam int CNT_W = 16;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_SWREQ  = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_AUTO_BIT = 1;
  localparam int CTRL_CLR_BIT  = 2;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_TMO_BIT  = 1;
  localparam int STAT_OVR_BIT  = 2;
  localparam int STAT_ID_LSB   = 8;
  localparam int STAT_PEND_LSB = 16;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } sched_state_t;

endpackage

// File: rtl/nios_system_rr_arbiter.sv
// Round-robin pick: lowest pending index at or above ptr, else lowest pending overall (wrap).
// Purely combinational, zero latency; grant_vld is simply "anything pending".
module nios_system_rr_arbiter
  import nios_system_create_block_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  logic [NUM_REQ-1:0] upper;

  always_comb begin
    upper = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper[i] = pending[i] && (ID_W'(i) >= ptr);
    end
  end

  // Scan high to low so the lowest qualifying index is the last one written.
  always_comb begin
    grant_vld = |pending;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (upper != '0) begin
        if (upper[i]) grant_idx = ID_W'(i);
      end else if (pending[i]) begin
        grant_idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/nios_system_create_block_sched.sv
// Avalon-MM spawn scheduler: hw/sw/timer requests arbitrated round-robin into a one-cycle create pulse.
// Pending -> pulse in 1 cycle; no new grant until ack. Optional ack watchdog: CREATE_SCHED_TIMEOUT_EN.
module nios_system_create_block_sched
  import nios_system_create_block_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_REQ-1:0]  hw_req,
  output logic                create_pulse,
  output logic [ID_W-1:0]     create_id,
  input  logic                create_ack,
  output logic                busy
);

  sched_state_t         state;
  logic                 ctrl_en;
  logic                 ctrl_auto;
  logic [PERIOD_W-1:0]  period;
  logic [PERIOD_W-1:0]  tmr;
  logic [NUM_REQ-1:0]   pending;
  logic [NUM_REQ-1:0]   hw_req_q;
  logic [NUM_REQ-1:0]   set_vec;
  logic [NUM_REQ-1:0]   grant_mask;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_vld;
  logic                 grant_fire;
  logic                 ack_take;
  logic                 tmo_hit;
  logic                 overrun_sticky;
  logic                 timeout_sticky;
  logic [CNT_W-1:0]     spawn_cnt;
  logic                 wr_en;
  logic                 ctrl_wr;
  logic                 period_wr;
  logic                 swreq_wr;
  logic                 sticky_clr;
  logic                 timer_on;
  logic                 timer_fire;
  logic [7:0]           pend8;
  logic                 unused_wdata;

  assign wr_en      = chipselect && !write_n;
  assign ctrl_wr    = wr_en && (address == ADDR_CTRL);
  assign period_wr  = wr_en && (address == ADDR_PERIOD);
  assign swreq_wr   = wr_en && (address == ADDR_SWREQ);
  assign sticky_clr = ctrl_wr && writedata[CTRL_CLR_BIT];
  assign unused_wdata = ^writedata;

  assign timer_on   = ctrl_auto && (period != '0);
  assign timer_fire = timer_on && (tmr >= period - PERIOD_W'(1));

  nios_system_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .pending   (pending),
    .ptr       (ptr),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign grant_fire = (state == ST_IDLE) && ctrl_en && grant_vld;
  // The ack has to come after the pulse cycle, so an ack overlapping the pulse is dropped.
  assign ack_take   = (state == ST_WAIT_ACK) && create_ack && !create_pulse;

  always_comb begin
    set_vec = hw_req & ~hw_req_q;
    if (swreq_wr) set_vec = set_vec | writedata[NUM_REQ-1:0];
    if (timer_fire) set_vec[NUM_REQ-1] = 1'b1;
    grant_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_mask[i] = grant_fire && (grant_idx == ID_W'(i));
    end
  end

  // A set landing on the bit being granted re-arms it rather than counting as an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en        <= 1'b0;
      ctrl_auto      <= 1'b0;
      period         <= '0;
      tmr            <= '0;
      pending        <= '0;
      hw_req_q       <= '0;
      overrun_sticky <= 1'b0;
    end else begin
      hw_req_q <= hw_req;
      pending  <= (pending & ~grant_mask) | set_vec;
      overrun_sticky <= (overrun_sticky && !sticky_clr) || (|(set_vec & pending & ~grant_mask));
      if (!timer_on || timer_fire) tmr <= '0;
      else                         tmr <= tmr + PERIOD_W'(1);
      if (ctrl_wr) begin
        ctrl_en   <= writedata[CTRL_EN_BIT];
        ctrl_auto <= writedata[CTRL_AUTO_BIT];
      end
      if (period_wr) period <= writedata[PERIOD_W-1:0];
    end
  end

`ifdef CREATE_SCHED_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'hFFFE;
  logic [15:0] wd_cnt;

  // Limit is one short of all-ones so busy stays high for exactly 65535 cycles.
  assign tmo_hit = (state == ST_WAIT_ACK) && !ack_take && (wd_cnt == WD_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt         <= '0;
      timeout_sticky <= 1'b0;
    end else begin
      if (grant_fire)                wd_cnt <= '0;
      else if (state == ST_WAIT_ACK) wd_cnt <= wd_cnt + 16'd1;
      timeout_sticky <= (timeout_sticky && !sticky_clr) || tmo_hit;
    end
  end
`else
  assign tmo_hit        = 1'b0;
  assign timeout_sticky = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      create_pulse <= 1'b0;
      create_id    <= '0;
      busy         <= 1'b0;
      ptr          <= '0;
      spawn_cnt    <= '0;
    end else begin
      create_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            create_pulse <= 1'b1;
            create_id    <= grant_idx;
            busy         <= 1'b1;
            ptr          <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            state        <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_take) begin
            busy      <= 1'b0;
            spawn_cnt <= spawn_cnt + CNT_W'(1);
            state     <= ST_IDLE;
          end else if (tmo_hit) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    pend8 = '0;
    pend8[NUM_REQ-1:0] = pending;
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_EN_BIT]   = ctrl_en;
        readdata[CTRL_AUTO_BIT] = ctrl_auto;
      end
      ADDR_PERIOD: readdata = 32'(period);
      ADDR_STATUS: begin
        readdata[STAT_BUSY_BIT] = busy;
        readdata[STAT_TMO_BIT]  = timeout_sticky;
        readdata[STAT_OVR_BIT]  = overrun_sticky;
        readdata[STAT_ID_LSB +: ID_W]  = create_id;
        readdata[STAT_PEND_LSB +: 8]   = pend8;
      end
      ADDR_SWREQ: readdata[CNT_W-1:0] = spawn_cnt;
    endcase
  end

endmodule

// File: tb/tb_nios_system_create_block_sched.sv
// Bench for the spawn scheduler: directed scenarios plus a random phase, every cycle checked against
// a request-level reference model (pending set, rotating search, ack/timeout bookkeeping).
module tb_nios_system_create_block_sched;

  localparam int NR = 4;
  localparam int PW = 24;
`ifdef CREATE_SCHED_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [NR-1:0] hw_req;
  logic          create_pulse;
  logic [2:0]    create_id;
  logic          create_ack;
  logic          busy;

  always #5 clk = ~clk;

  nios_system_create_block_sched #(.NUM_REQ(NR), .PERIOD_W(PW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .hw_req       (hw_req),
    .create_pulse (create_pulse),
    .create_id    (create_id),
    .create_ack   (create_ack),
    .busy         (busy)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  bit          m_en, m_auto, m_busy, m_pulse, m_ovr, m_to;
  int          m_period, m_ptr, m_age, m_wd;
  bit [NR-1:0] m_pend, m_hwq;
  bit [2:0]    m_id;
  bit [15:0]   m_cnt;

  int got_id[$];
  int got_t[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_busy = 0; m_pulse = 0; m_ovr = 0; m_to = 0;
    m_period = 0; m_ptr = 0; m_age = 0; m_wd = 0;
    m_pend = '0; m_hwq = '0; m_id = '0; m_cnt = '0;
  endtask

  // One clock edge of the scheduler, computed from the current (pre-edge) inputs.
  task automatic model_step();
    bit wr, fire, found, tmo;
    bit [NR-1:0] setv, gm;
    int idx;
    wr = chipselect && !write_n;
    fire = 0; found = 0; tmo = 0; idx = 0; gm = '0;
    if (m_auto && m_period != 0) begin
      fire = (m_age % m_period) == (m_period - 1);
      m_age++;
    end else begin
      m_age = 0;
    end
    setv = hw_req & ~m_hwq;
    if (fire) setv[NR-1] = 1'b1;
    if (wr && address == 2'd3) setv = setv | writedata[NR-1:0];
    if (m_busy) begin
      if (create_ack && !m_pulse) begin
        m_busy = 0; m_cnt++;
      end else begin
        m_wd++;
        if (TMO && m_wd == 65535) begin m_busy = 0; tmo = 1; end
      end
    end else if (m_en && m_pend != '0) begin
      for (int k = 0; k < NR; k++) begin
        if (!found && m_pend[(m_ptr + k) % NR]) begin found = 1; idx = (m_ptr + k) % NR; end
      end
      gm[idx] = 1'b1; m_id = idx[2:0]; m_ptr = (idx + 1) % NR; m_busy = 1; m_wd = 0;
    end
    m_pulse = found;
    if (wr && address == 2'd0 && writedata[2]) begin m_ovr = 0; m_to = 0; end
    if ((setv & m_pend & ~gm) != '0) m_ovr = 1;
    if (tmo) m_to = 1;
    m_pend = (m_pend & ~gm) | setv;
    m_hwq = hw_req;
    if (wr && address == 2'd0) begin m_en = writedata[0]; m_auto = writedata[1]; end
    if (wr && address == 2'd1) m_period = int'(writedata[PW-1:0]);
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r = {30'd0, m_auto, m_en};
      2'd1: r = 32'(m_period);
      2'd2: begin r[0] = m_busy; r[1] = m_to; r[2] = m_ovr; r[10:8] = m_id; r[16 +: NR] = m_pend; end
      default: r = {16'd0, m_cnt};
    endcase
    return r;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    cyc++;
    check("pulse", create_pulse, m_pulse);
    check("id", create_id, m_id);
    check("busy", busy, m_busy);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    tick();
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd_model(input string tag, input logic [1:0] a);
    address = a; #1;
    check(tag, readdata, model_read(a));
  endtask

  task automatic rd_const(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a; #1;
    check(tag, readdata, exp);
  endtask

  task automatic do_reset();
    reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0;
    hw_req = '0; create_ack = 0;
    #1; model_reset();
    repeat (2) @(posedge clk);
    #1; reset_n = 1;
  endtask

  // Runs until npulse pulses have been seen and acked dly cycles after each pulse.
  task automatic serve(input string tag, input int npulse, input int dly, input int budget);
    int seen, wait_cnt;
    seen = 0; wait_cnt = -1;
    got_id.delete(); got_t.delete();
    for (int c = 0; c < budget && (seen < npulse || wait_cnt >= 0); c++) begin
      create_ack = (wait_cnt == 0);
      tick();
      if (wait_cnt > 0) wait_cnt--;
      else if (wait_cnt == 0) wait_cnt = -1;
      if (create_pulse) begin
        got_id.push_back(int'(create_id)); got_t.push_back(cyc);
        seen++; wait_cnt = dly;
      end
    end
    create_ack = 0;
    check({tag, "_pulse_count"}, seen, npulse);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, cycles=%0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int exp_ids[3];
    int npul;

    // Reset state
    do_reset();
    check("rst_pulse", create_pulse, 0);
    check("rst_id", create_id, 0);
    check("rst_busy", busy, 0);
    for (int a = 0; a < 4; a++) rd_const("rst_reg", 2'(a), 32'd0);

    // 1: single hw request, one-cycle pulse, ack
    bus_write(2'd0, 32'd1);
    hw_req = 4'b0100; tick(); hw_req = '0;
    check("t1_no_pulse_yet", create_pulse, 0);
    tick();
    check("t1_pulse", create_pulse, 1);
    check("t1_id", create_id, 2);
    check("t1_busy", busy, 1);
    tick();
    check("t1_pulse_one_cycle", create_pulse, 0);
    create_ack = 1; tick(); create_ack = 0;
    check("t1_busy_clr", busy, 0);
    rd_const("t1_cnt", 2'd3, 32'd1);

    // 2: software request burst from ptr=0
    do_reset();
    bus_write(2'd0, 32'd1);
    bus_write(2'd3, 32'hB);
    serve("t2", 3, 3, 200);
    exp_ids = '{0, 1, 3};
    check("t2_nids", got_id.size(), 3);
    for (int i = 0; i < got_id.size() && i < 3; i++) check("t2_id_order", got_id[i], exp_ids[i]);
    rd_const("t2_cnt", 2'd3, 32'd3);
    address = 2'd2; #1;
    check("t2_pend_empty", {24'd0, readdata[23:16]}, 32'd0);

    // 3: coalesced request sets overrun, CTRL[2] clears it
    bus_write(2'd0, 32'd0);
    hw_req = 4'b0010; tick(); hw_req = '0; tick();
    hw_req = 4'b0010; tick(); hw_req = '0; tick();
    address = 2'd2; #1;
    check("t3_overrun", readdata[2], 1);
    check("t3_pend1", readdata[17], 1);
    bus_write(2'd0, 32'd1);
    serve("t3", 1, 1, 50);
    if (got_id.size() > 0) check("t3_id", got_id[0], 1);
    repeat (10) tick();
    rd_const("t3_cnt", 2'd3, 32'd4);
    bus_write(2'd0, 32'd4);
    address = 2'd2; #1;
    check("t3_overrun_clr", readdata[2], 0);
    rd_model("t3_status", 2'd2);

    // 4: auto-spawn timer
    bus_write(2'd1, 32'd100);
    bus_write(2'd0, 32'd3);
    serve("t4", 3, 1, 400);
    for (int i = 0; i < got_id.size(); i++) check("t4_id", got_id[i], 3);
    for (int i = 1; i < got_t.size(); i++) check("t4_interval", got_t[i] - got_t[i-1], 100);
    bus_write(2'd1, 32'd0);
    npul = 0;
    for (int i = 0; i < 250; i++) begin tick(); if (create_pulse) npul++; end
    check("t4_stopped", npul, 0);
    rd_model("t4_period", 2'd1);

    // 5: reset in the middle of a spawn
    bus_write(2'd0, 32'd1);
    bus_write(2'd3, 32'd4);
    tick(); tick();
    check("t5_busy_before", busy, 1);
    reset_n = 0; #1;
    check("t5_rst_pulse", create_pulse, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_id", create_id, 0);
    rd_const("t5_rst_status", 2'd2, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1; reset_n = 1;
    create_ack = 1; tick(); create_ack = 0;
    tick();
    check("t5_post_busy", busy, 0);
    rd_const("t5_post_cnt", 2'd3, 32'd0);

    // Random traffic against the model
    do_reset();
    bus_write(2'd1, 32'd29);
    bus_write(2'd0, 32'd3);
    for (int i = 0; i < 2000; i++) begin
      int r;
      hw_req = NR'($urandom);
      create_ack = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 39);
      address = 2'($urandom);
      writedata = $urandom;
      chipselect = 0; write_n = 1;
      if (r < 4) begin
        chipselect = 1; write_n = 0; address = 2'd3;
      end else if (r == 4) begin
        chipselect = 1; write_n = 0; address = 2'd0;
        writedata = {29'd0, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0)};
      end
      tick();
      check("rnd_readdata", readdata, model_read(address));
    end
    chipselect = 0; write_n = 1; hw_req = '0; create_ack = 0;
    rd_model("rnd_status", 2'd2);
    rd_model("rnd_cnt", 2'd3);

`ifdef CREATE_SCHED_TIMEOUT_EN
    // 6: ack never arrives
    do_reset();
    bus_write(2'd0, 32'd1);
    bus_write(2'd3, 32'd1);
    tick();
    check("t6_busy", busy, 1);
    repeat (65536) tick();
    check("t6_busy_drop", busy, 0);
    address = 2'd2; #1;
    check("t6_tmo_sticky", readdata[1], 1);
    rd_const("t6_cnt", 2'd3, 32'd0);
`else
    address = 2'd2; #1;
    check("no_tmo_sticky", readdata[1], 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
